// File: rtl/aes_cbc_dec_ctrl.sv
// -----------------------------------------------------------------------------
// aes_cbc_dec_ctrl
//
// CBC-mode decryption controller wrapped around an AES decipher core. Ciphertext
// blocks enter over a valid/ready port. Each block is handed to the core with a
// one-cycle core_next pulse. The core result is XORed with the previous
// ciphertext (or the IV for the first block) and presented as plaintext over a
// valid/ready port. Only one block is in flight at a time. A new block can be
// accepted while the previous plaintext is still waiting for the downstream
// side, so output backpressure overlaps with the next decryption.
//
// Handshake rule, used by both ports: a transfer happens on a rising clk edge
// where valid and ready are both high. While valid is high and ready is low, the
// producer holds valid and data unchanged.
//
// Ports:
//   clk, reset_n     clock and asynchronous active-low reset
//   init, iv         one-cycle pulse that loads iv as the chaining value
//                    (accepted only in IDLE)
//   in_valid/ready   ciphertext input handshake, with in_block[127:0]
//   out_valid/ready  plaintext output handshake, with out_block[127:0]
//   core_next        one-cycle start pulse to the decipher core
//   core_block       ciphertext presented to the core
//   core_new_block   core result
//   core_ready       core idle/done
//   iv_loaded        a chaining value is valid
//   busy             FSM not in IDLE
//   dbg_state        FSM state: 0 IDLE, 1 ISSUE, 2 WAIT, 3 HOLD
// -----------------------------------------------------------------------------
module aes_cbc_dec_ctrl (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         init,
  input  logic [127:0] iv,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_block,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_block,
  output logic         core_next,
  output logic [127:0] core_block,
  input  logic [127:0] core_new_block,
  input  logic         core_ready,
  output logic         iv_loaded,
  output logic         busy,
  output logic [1:0]   dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t       r_state;
  logic [127:0] r_ct;
  logic [127:0] r_chain;
  logic [127:0] r_out;
  logic         r_out_valid;
  logic         r_iv_loaded;
  logic         r_core_next;
  logic         r_wait_first;

  logic w_slot_free;
  logic w_accept;
  logic w_core_done;
  logic w_result;

  // The output register can take a new result when it is empty or being
  // drained on this edge.
  assign w_slot_free = !r_out_valid || out_ready;

  // init takes priority over a simultaneous input block.
  assign in_ready = (r_state == S_IDLE) && r_iv_loaded && !init;
  assign w_accept = in_valid && in_ready;

  // The core drops ready one cycle after next. The first WAIT cycle is
  // skipped so that a ready level left over from before the start is never
  // taken as the result.
  assign w_core_done = (r_state == S_WAIT) && !r_wait_first && core_ready;

  // In HOLD the core is idle and keeps new_block stable, so the result stays
  // valid until the output slot frees.
  assign w_result = (w_core_done || (r_state == S_HOLD)) && w_slot_free;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_ct         <= '0;
      r_chain      <= '0;
      r_out        <= '0;
      r_out_valid  <= 1'b0;
      r_iv_loaded  <= 1'b0;
      r_core_next  <= 1'b0;
      r_wait_first <= 1'b0;
    end else begin
      r_core_next <= 1'b0;

      // A drained output empties the slot unless a result lands on the same
      // edge (handled just below).
      if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end

      if (w_result) begin
        r_out       <= core_new_block ^ r_chain;
        r_out_valid <= 1'b1;
        r_chain     <= r_ct;
      end

      case (r_state)
        S_IDLE: begin
          if (init) begin
            r_chain     <= iv;
            r_iv_loaded <= 1'b1;
          end else if (w_accept) begin
            r_ct        <= in_block;
            r_core_next <= 1'b1;
            r_state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_wait_first <= 1'b1;
          r_state      <= S_WAIT;
        end
        S_WAIT: begin
          r_wait_first <= 1'b0;
          if (w_core_done) begin
            r_state <= w_slot_free ? S_IDLE : S_HOLD;
          end
        end
        S_HOLD: begin
          if (w_slot_free) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign out_valid  = r_out_valid;
  assign out_block  = r_out;
  assign core_next  = r_core_next;
  assign core_block = r_ct;
  assign iv_loaded  = r_iv_loaded;
  assign busy       = (r_state != S_IDLE);
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_aes_cbc_dec_ctrl.sv
// -----------------------------------------------------------------------------
// tb_aes_cbc_dec_ctrl
//
// Bench for aes_cbc_dec_ctrl. A behavioural stand-in for the AES decipher core
// returns the true AES-128 decryption for the two NIST SP800-38A ciphertexts,
// and a fixed invertible scramble for any other block. Its latency is random.
// The reference model works at the block level. Every accepted ciphertext
// yields the plaintext D(ct) ^ chain, then becomes the chain. Plaintexts queue
// in exp_q in the order they must leave the design.
// -----------------------------------------------------------------------------
module tb_aes_cbc_dec_ctrl;

  localparam logic [127:0] IV0 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT1 = 128'h7649abac8119b246cee98e9b12e9197d;
  localparam logic [127:0] CT2 = 128'h5086cb9b507219ee95db113a917678b2;
  localparam logic [127:0] PT1 = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] PT2 = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] SCR = 128'h5a5a_a5a5_3c3c_c3c3_0ff0_f00f_9669_6996;

  // clock / reset and DUT signals
  logic         clk = 1'b0;
  logic         reset_n;
  logic         init;
  logic [127:0] iv;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_block;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_block;
  logic         core_next;
  logic [127:0] core_block;
  logic [127:0] core_new_block;
  logic         core_ready;
  logic         iv_loaded;
  logic         busy;
  logic [1:0]   dbg_state;

  always #5 clk = ~clk;

  aes_cbc_dec_ctrl dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .init           (init),
    .iv             (iv),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_block       (in_block),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_block      (out_block),
    .core_next      (core_next),
    .core_block     (core_block),
    .core_new_block (core_new_block),
    .core_ready     (core_ready),
    .iv_loaded      (iv_loaded),
    .busy           (busy),
    .dbg_state      (dbg_state)
  );

  // AES-128 decryption (key 2b7e151628aed2a6abf7158809cf4f3c) for the NIST
  // blocks: D(CTn) = PTn ^ previous chaining value.
  function automatic logic [127:0] core_f(input logic [127:0] ct);
    if (ct == CT1) return PT1 ^ IV0;
    if (ct == CT2) return PT2 ^ CT1;
    return {ct[63:0], ct[127:64]} ^ SCR;
  endfunction

  // decipher core stand-in: ready drops on the edge that sees next, comes back
  // 2..6 cycles later with the result, which then stays stable while idle
  logic [127:0] core_pend;
  int           core_cnt;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      core_ready     <= 1'b1;
      core_new_block <= '0;
      core_pend      <= '0;
      core_cnt       <= 0;
    end else if (core_next) begin
      core_ready <= 1'b0;
      core_pend  <= core_block;
      core_cnt   <= int'($urandom_range(2, 6));
    end else if (!core_ready) begin
      if (core_cnt == 1) begin
        core_ready     <= 1'b1;
        core_new_block <= core_f(core_pend);
      end
      core_cnt <= core_cnt - 1;
    end
  end

  // scoreboard state
  logic [127:0] exp_q[$];
  logic [127:0] chain_m;
  int           n_checks = 0;
  int           n_errors = 0;
  int           n_acc    = 0;
  int           n_next   = 0;
  bit           rand_ready;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // cycle monitor, sampled on the falling edge
  logic         prev_acc;
  logic         prev_hold;
  logic [127:0] prev_blk;
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_acc  = 1'b0;
      prev_hold = 1'b0;
    end else begin
      chk("core_next_timing", {127'b0, core_next}, {127'b0, prev_acc});
      if (core_next) n_next++;
      if (prev_hold) begin
        chk("stall_out_valid", {127'b0, out_valid}, 128'd1);
        chk("stall_out_block", out_block, prev_blk);
      end
      if (out_valid && out_ready) begin
        chk("out_expected", {127'b0, exp_q.size() != 0}, 128'd1);
        if (exp_q.size() != 0) chk("out_block", out_block, exp_q.pop_front());
      end
      prev_acc = in_valid && in_ready;
      if (prev_acc) begin
        n_acc++;
        exp_q.push_back(core_f(in_block) ^ chain_m);
        chain_m = in_block;
      end
      prev_hold = out_valid && !out_ready;
      prev_blk  = out_block;
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic do_init(input logic [127:0] v, input bit accept_exp);
    init = 1'b1;
    iv   = v;
    if (accept_exp) chain_m = v;
    tick();
    init = 1'b0;
  endtask

  task automatic send_block(input logic [127:0] ct);
    int   k   = 0;
    logic got = 1'b0;
    in_valid = 1'b1;
    in_block = ct;
    while (!got && k < 300) begin
      #1 got = in_ready;
      tick();
      k++;
    end
    in_valid = 1'b0;
    chk("accept_timeout", {127'b0, got}, 128'd1);
  endtask

  task automatic wait_out();
    int k = 0;
    while (!out_valid && k < 300) begin
      tick();
      k++;
    end
    chk("out_valid_timeout", {127'b0, out_valid}, 128'd1);
  endtask

  task automatic wait_state(input logic [1:0] s);
    int k = 0;
    while (dbg_state != s && k < 300) begin
      tick();
      k++;
    end
    chk("state_timeout", {126'b0, dbg_state}, {126'b0, s});
  endtask

  task automatic drain();
    int k = 0;
    while ((exp_q.size() != 0 || busy || out_valid) && k < 1000) begin
      tick();
      k++;
    end
    chk("drain_timeout", {127'b0, k < 1000}, 128'd1);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_out_valid"}, {127'b0, out_valid}, 128'd0);
    chk({tag, "_in_ready"},  {127'b0, in_ready},  128'd0);
    chk({tag, "_iv_loaded"}, {127'b0, iv_loaded}, 128'd0);
    chk({tag, "_busy"},      {127'b0, busy},      128'd0);
    chk({tag, "_core_next"}, {127'b0, core_next}, 128'd0);
  endtask

  initial begin
    logic [127:0] v;
    reset_n    = 1'b0;
    init       = 1'b0;
    iv         = '0;
    in_valid   = 1'b0;
    in_block   = '0;
    out_ready  = 1'b1;
    rand_ready = 1'b0;
    chain_m    = '0;

    // reset values
    repeat (3) @(posedge clk);
    #1;
    chk_quiet("reset");
    chk("reset_out_block", out_block, 128'd0);
    reset_n = 1'b1;
    tick();
    chk_quiet("post_reset");

    // reset asserted mid-WAIT
    do_init(IV0, 1'b1);
    send_block(CT1);
    tick();
    chk("mid_wait_state", {126'b0, dbg_state}, 128'd2);
    #2 reset_n = 1'b0;
    #1;
    chk_quiet("in_reset");
    tick();
    tick();
    exp_q.delete();
    reset_n = 1'b1;
    tick();
    chk_quiet("after_reset");
    repeat (10) tick();
    chk("no_stale_out", {127'b0, out_valid}, 128'd0);

    // no IV: block stalls, then init unblocks it
    in_valid = 1'b1;
    in_block = CT1;
    for (int i = 0; i < 100; i++) begin
      chk("no_iv_in_ready", {127'b0, in_ready}, 128'd0);
      chk("no_iv_core_next", {127'b0, core_next}, 128'd0);
      tick();
    end

    // NIST vectors back to back, output always ready
    do_init(IV0, 1'b1);
    send_block(CT1);
    wait_out();
    chk("nist_pt1", out_block, PT1);
    send_block(CT2);
    wait_out();
    chk("nist_pt2", out_block, PT2);
    drain();

    // backpressure through both blocks
    out_ready = 1'b0;
    do_init(IV0, 1'b1);
    send_block(CT1);
    wait_out();
    chk("bp_pt1", out_block, PT1);
    send_block(CT2);
    wait_state(2'd3);
    chk("bp_hold_block", out_block, PT1);
    chk("bp_hold_valid", {127'b0, out_valid}, 128'd1);
    out_ready = 1'b1;
    tick();
    chk("bp_pt2_valid", {127'b0, out_valid}, 128'd1);
    chk("bp_pt2", out_block, PT2);
    tick();
    chk("bp_empty", {127'b0, out_valid}, 128'd0);
    drain();

    // init and in_valid in the same IDLE cycle
    v        = rand128();
    init     = 1'b1;
    iv       = v;
    chain_m  = v;
    in_valid = 1'b1;
    in_block = rand128();
    #1;
    chk("collide_in_ready", {127'b0, in_ready}, 128'd0);
    tick();
    init = 1'b0;
    #1;
    chk("collide_in_ready_next", {127'b0, in_ready}, 128'd1);
    chk("collide_iv_loaded", {127'b0, iv_loaded}, 128'd1);
    tick();
    in_valid = 1'b0;
    chk("collide_core_next", {127'b0, core_next}, 128'd1);
    drain();

    // init during WAIT is ignored
    send_block(rand128());
    tick();
    chk("init_wait_state", {126'b0, dbg_state}, 128'd2);
    do_init(rand128(), 1'b0);
    chk("init_wait_iv_loaded", {127'b0, iv_loaded}, 128'd1);
    drain();

    // random blocks with random output backpressure
    rand_ready = 1'b1;
    do_init(rand128(), 1'b1);
    for (int i = 0; i < 8; i++) begin
      send_block(rand128());
      repeat ($urandom_range(0, 3)) tick();
    end
    drain();
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    tick();

    chk("pulse_count", 128'(n_next), 128'(n_acc));
    chk("queue_empty", 128'(exp_q.size()), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not reach the end, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/aes_cbc_dec_ctrl.md
Name: aes_cbc_dec_ctrl

Overview:
- Chaining controller wrapped around the AES decipher core to implement CBC-mode decryption of a block stream.
- Accepts ciphertext blocks over a valid/ready interface and drives the core's next/block inputs.
- Consumes the core's new_block when its ready returns high, XORs it with the previous ciphertext (or the IV for the first block), and presents the plaintext over a valid/ready output.
- Round-key generation is outside this block; the core's round/round_key connect to the key memory as today.

Parameters:
- none

Ports:
- clk  in  1  system clock, all flops rising-edge.
- reset_n  in  1  asynchronous active-low reset.
- init  in  1  single-cycle pulse: load iv as the chaining value.
- iv  in  128  initialisation vector, sampled when init is accepted.
- in_valid  in  1  ciphertext block available.
- in_ready  out  1  block accepts in_block this cycle.
- in_block  in  128  ciphertext block.
- out_valid  out  1  plaintext block available.
- out_ready  in  1  downstream takes out_block this cycle.
- out_block  out  128  plaintext block.
- core_next  out  1  one-cycle start pulse to the decipher core.
- core_block  out  128  ciphertext presented to the core; equals ct_reg.
- core_new_block  in  128  core result.
- core_ready  in  1  core idle/done; high out of reset; falls the cycle after next.
- iv_loaded  out  1  a chaining value is valid.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Registers:
  - ct_reg[127:0]: current ciphertext.
  - chain_reg[127:0]: previous ciphertext or IV.
  - out_reg[127:0]
  - out_valid_reg, iv_loaded_reg
  - 2-bit state
- Reset values: all data registers 0; out_valid, iv_loaded, busy, core_next, in_ready all 0; state IDLE.
- States: IDLE, ISSUE, WAIT, HOLD.
- init handling:
  - Accepted only in IDLE: chain_reg <= iv, iv_loaded <= 1.
  - Ignored in any other state.
  - Does not disturb a pending out_valid.
- in_ready = (state==IDLE) & iv_loaded & !init. Init wins over a simultaneous in_valid.
- IDLE: on in_valid & in_ready, ct_reg <= in_block and go to ISSUE.
- ISSUE: core_next=1 for exactly this cycle, then go to WAIT. core_block is stable from ISSUE until the result is consumed.
- WAIT:
  - core_ready is not sampled in the first WAIT cycle, where it is guaranteed low because the core drops it one cycle after next.
  - From the second WAIT cycle on, core_ready==1 means the result is valid.
  - If the output slot is free (!out_valid | out_ready): out_reg <= core_new_block ^ chain_reg, out_valid <= 1, chain_reg <= ct_reg, go to IDLE.
  - Otherwise go to HOLD.
- HOLD: the core holds new_block stable while idle. When the output slot frees, perform the same update as WAIT and go to IDLE.
- Output handshake:
  - out_valid falls on out_ready unless a new result is written in the same cycle, in which case it stays 1 with the new data.
  - out_block and out_valid must not change while out_valid & !out_ready.
- Throughput: one block in flight. A new input is accepted in IDLE even while out_valid is pending, so output backpressure overlaps with the next decryption.
- Latency: from core_ready rising to out_valid is 1 cycle when the slot is free. Accept to core_next is 1 cycle.
- in_valid with iv_loaded=0: in_ready stays 0 and the block stalls indefinitely.
- Reset mid-operation: all state is cleared and iv_loaded=0. The core is reset by the same reset_n, so no stale result is consumed.
- XOR is bitwise over 128 bits, with no width change.

Test Plan:
1. Reset: assert reset_n=0 mid-WAIT.
   - Required: out_valid=0, in_ready=0, iv_loaded=0, busy=0, core_next=0 during reset and after release.
2. Back-to-back NIST SP800-38A CBC-AES128 vectors, with the real core and key 2b7e151628aed2a6abf7158809cf4f3c.
   - Stimulus: init with IV 000102030405060708090a0b0c0d0e0f; CT1 7649abac8119b246cee98e9b12e9197d, then CT2 5086cb9b507219ee95db113a917678b2, with out_ready=1.
   - Required: PT1 6bc1bee22e409f96e93d7e117393172a, then PT2 ae2d8a571e03ac9c9eb76fac45af8e51.
3. Backpressure: hold out_ready=0 through both blocks of scenario 2.
   - Required: PT1 stays stable; block 2 is accepted and the FSM parks in HOLD.
   - On out_ready=1: PT1 is consumed and PT2 appears the next cycle, with no data loss.
4. No IV: in_valid=1 with no init.
   - Required: in_ready=0 for 100 cycles and core_next never asserts. A subsequent init unblocks the transfer.
5. Init collisions:
   - init and in_valid in the same IDLE cycle: iv is loaded and the block is accepted one cycle later.
   - init during WAIT: ignored, so PT equals the value computed with the old chain.
6. Pulse check: exactly one core_next per accepted block, asserted one cycle after acceptance, across 8 random blocks compared against a reference model.
